// File: rtl/vtage_bank_pipe.sv
// vtage_bank_pipe: registered VTAGE tagged bank with multi-port lookup/update and usefulness aging
module vtage_bank_pipe #(
    parameter int P_NUM_PRED    = 2,
    parameter int P_NUM_ENTRIES = 256,
    parameter int P_VALUE_WIDTH = 32,
    parameter int P_TAG_WIDTH   = 8,
    parameter int P_CONF_WIDTH  = 3,
    parameter int P_U_WIDTH     = 2,
    parameter int P_AGE_THRESH  = 64,
    localparam int LP_INDEX_WIDTH = $clog2(P_NUM_ENTRIES)
) (
    input  logic                                       clk_i,
    input  logic                                       rst_ni,
    input  logic [P_NUM_PRED-1:0]                      fw_valid_i,
    input  logic [P_NUM_PRED-1:0][LP_INDEX_WIDTH-1:0]  fw_index_i,
    input  logic [P_NUM_PRED-1:0][P_TAG_WIDTH-1:0]     fw_tag_i,
    output logic [P_NUM_PRED-1:0]                      pred_valid_o,
    output logic [P_NUM_PRED-1:0]                      pred_hit_o,
    output logic [P_NUM_PRED-1:0][P_VALUE_WIDTH-1:0]   pred_value_o,
    output logic [P_NUM_PRED-1:0][P_CONF_WIDTH-1:0]    pred_conf_o,
    output logic [P_NUM_PRED-1:0][P_U_WIDTH-1:0]       pred_useful_o,
    input  logic [P_NUM_PRED-1:0]                      ud_valid_i,
    input  logic [P_NUM_PRED-1:0][LP_INDEX_WIDTH-1:0]  ud_index_i,
    input  logic [P_NUM_PRED-1:0][1:0]                 ud_op_i,
    input  logic [P_NUM_PRED-1:0][P_TAG_WIDTH-1:0]     ud_tag_i,
    input  logic [P_NUM_PRED-1:0][P_VALUE_WIDTH-1:0]   ud_value_i,
    output logic [P_NUM_PRED-1:0]                      ud_ack_o,
    output logic [P_NUM_PRED-1:0]                      ud_refused_o,
    output logic                                       aging_o
);
    localparam int LP_AGE_WIDTH = $clog2(P_AGE_THRESH + 1);

    typedef enum logic {IDLE, SWEEP} state_e;

    state_e                       state_q, state_d;
    logic [LP_INDEX_WIDTH-1:0]    ptr_q, ptr_d;
    logic [LP_AGE_WIDTH-1:0]      age_q, age_d;
    logic [31:0]                  age_sum;

    logic                         valid_q  [P_NUM_ENTRIES];
    logic [P_TAG_WIDTH-1:0]       tag_q    [P_NUM_ENTRIES];
    logic [P_VALUE_WIDTH-1:0]     value_q  [P_NUM_ENTRIES];
    logic [P_CONF_WIDTH-1:0]      conf_q   [P_NUM_ENTRIES];
    logic [P_U_WIDTH-1:0]         useful_q [P_NUM_ENTRIES];

    logic [P_NUM_PRED-1:0]        acc, refused, sweep_hit_p;
    logic                         sweep_hit;

    assign aging_o   = (state_q == SWEEP);
    assign sweep_hit = |sweep_hit_p;

    // Port arbitration: lowest port wins an index; refusal when the target entry is still useful
    always_comb begin
        acc         = ud_valid_i;
        refused     = '0;
        sweep_hit_p = '0;
        for (int p = 0; p < P_NUM_PRED; p++) begin
            for (int q = 0; q < p; q++)
                if (ud_valid_i[q] && ud_index_i[q] == ud_index_i[p]) acc[p] = 1'b0;
            refused[p]     = acc[p] && ud_op_i[p] == 2'b10 && valid_q[ud_index_i[p]] && useful_q[ud_index_i[p]] != '0;
            sweep_hit_p[p] = acc[p] && ud_index_i[p] == ptr_q;
        end
    end

    // Aging FSM next state: saturating refusal counter, sweep pointer walk
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        age_sum = 32'(age_q);
        for (int p = 0; p < P_NUM_PRED; p++) age_sum = age_sum + 32'(refused[p]);
        age_d = (age_sum >= 32'(P_AGE_THRESH)) ? LP_AGE_WIDTH'(P_AGE_THRESH) : LP_AGE_WIDTH'(age_sum);
        if (state_q == IDLE && 32'(age_q) >= 32'(P_AGE_THRESH)) begin
            state_d = SWEEP;
            ptr_d   = '0;
            age_d   = '0;
        end else if (state_q == SWEEP) begin
            ptr_d = ptr_q + LP_INDEX_WIDTH'(1);
            if (ptr_q == LP_INDEX_WIDTH'(P_NUM_ENTRIES - 1)) state_d = IDLE;
        end
    end

    // Control registers and registered lookup/update responses
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            age_q         <= '0;
            ud_ack_o      <= '0;
            ud_refused_o  <= '0;
            pred_valid_o  <= '0;
            pred_hit_o    <= '0;
            pred_value_o  <= '0;
            pred_conf_o   <= '0;
            pred_useful_o <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            age_q        <= age_d;
            ud_ack_o     <= acc;
            ud_refused_o <= refused;
            pred_valid_o <= fw_valid_i;
            for (int p = 0; p < P_NUM_PRED; p++) begin
                pred_hit_o[p]    <= fw_valid_i[p] && valid_q[fw_index_i[p]] && tag_q[fw_index_i[p]] == fw_tag_i[p];
                pred_value_o[p]  <= fw_valid_i[p] ? value_q[fw_index_i[p]] : '0;
                pred_conf_o[p]   <= fw_valid_i[p] ? conf_q[fw_index_i[p]] : '0;
                pred_useful_o[p] <= fw_valid_i[p] ? useful_q[fw_index_i[p]] : '0;
            end
        end
    end

    // Entry storage: sweep decay unless an update claims the swept entry, then port updates
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < P_NUM_ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                value_q[i]  <= '0;
                conf_q[i]   <= '0;
                useful_q[i] <= '0;
            end
        end else begin
            if (state_q == SWEEP && !sweep_hit && useful_q[ptr_q] != '0)
                useful_q[ptr_q] <= useful_q[ptr_q] - P_U_WIDTH'(1);
            for (int p = 0; p < P_NUM_PRED; p++) begin
                if (acc[p]) begin
                    case (ud_op_i[p])
                        2'b00: begin
                            conf_q[ud_index_i[p]]   <= &conf_q[ud_index_i[p]] ? conf_q[ud_index_i[p]] : conf_q[ud_index_i[p]] + P_CONF_WIDTH'(1);
                            useful_q[ud_index_i[p]] <= &useful_q[ud_index_i[p]] ? useful_q[ud_index_i[p]] : useful_q[ud_index_i[p]] + P_U_WIDTH'(1);
                        end
                        2'b01: begin
                            conf_q[ud_index_i[p]]   <= '0;
                            useful_q[ud_index_i[p]] <= (useful_q[ud_index_i[p]] == '0) ? '0 : useful_q[ud_index_i[p]] - P_U_WIDTH'(1);
                        end
                        2'b10: begin
                            if (!refused[p]) begin
                                valid_q[ud_index_i[p]]  <= 1'b1;
                                tag_q[ud_index_i[p]]    <= ud_tag_i[p];
                                value_q[ud_index_i[p]]  <= ud_value_i[p];
                                conf_q[ud_index_i[p]]   <= '0;
                                useful_q[ud_index_i[p]] <= '0;
                            end
                        end
                        default: valid_q[ud_index_i[p]] <= 1'b0;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_vtage_bank_pipe.sv
// tb_vtage_bank_pipe: directed scoreboard bench for the VTAGE bank
module tb_vtage_bank_pipe;
    localparam int NP = 2, NE = 256, VW = 32, TW = 8, CW = 3, UW = 2, AT = 4, IW = 8;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NP-1:0]          fw_valid = '0, pred_valid, pred_hit, ud_valid = '0, ud_ack, ud_refused;
    logic [NP-1:0][IW-1:0]  fw_index = '0, ud_index = '0;
    logic [NP-1:0][TW-1:0]  fw_tag = '0, ud_tag = '0;
    logic [NP-1:0][VW-1:0]  pred_value, ud_value = '0;
    logic [NP-1:0][CW-1:0]  pred_conf;
    logic [NP-1:0][UW-1:0]  pred_useful;
    logic [NP-1:0][1:0]     ud_op = '0;
    logic                   aging;

    vtage_bank_pipe #(.P_NUM_PRED(NP), .P_NUM_ENTRIES(NE), .P_VALUE_WIDTH(VW), .P_TAG_WIDTH(TW),
                      .P_CONF_WIDTH(CW), .P_U_WIDTH(UW), .P_AGE_THRESH(AT)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .fw_valid_i(fw_valid), .fw_index_i(fw_index), .fw_tag_i(fw_tag),
        .pred_valid_o(pred_valid), .pred_hit_o(pred_hit), .pred_value_o(pred_value),
        .pred_conf_o(pred_conf), .pred_useful_o(pred_useful),
        .ud_valid_i(ud_valid), .ud_index_i(ud_index), .ud_op_i(ud_op), .ud_tag_i(ud_tag),
        .ud_value_i(ud_value), .ud_ack_o(ud_ack), .ud_refused_o(ud_refused), .aging_o(aging)
    );

    typedef struct { string name; int port; int kind; logic [31:0] exp; } exp_t;
    exp_t sb[$];
    int checks = 0, passes = 0;

    task automatic chk(string name, int port, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s[%0d] observed=%h expected=%h", name, port, obs, exp);
    endtask

    function automatic logic [31:0] observe(int kind, int p);
        case (kind)
            0: return 32'(pred_valid[p]);
            1: return 32'(pred_hit[p]);
            2: return pred_value[p];
            3: return 32'(pred_conf[p]);
            4: return 32'(pred_useful[p]);
            5: return 32'(ud_ack[p]);
            default: return 32'(ud_refused[p]);
        endcase
    endfunction

    task automatic push(string name, int p, int kind, logic [31:0] v);
        exp_t e;
        e.name = name; e.port = p; e.kind = kind; e.exp = v;
        sb.push_back(e);
    endtask

    task automatic exp_pred(int p, logic v, logic h, logic [31:0] val, int c, int u);
        push("pred_valid", p, 0, 32'(v));
        push("pred_hit", p, 1, 32'(h));
        push("pred_value", p, 2, val);
        push("pred_conf", p, 3, c);
        push("pred_useful", p, 4, u);
    endtask

    task automatic exp_ud(int p, logic a, logic r);
        push("ud_ack", p, 5, 32'(a));
        push("ud_refused", p, 6, 32'(r));
    endtask

    task automatic fw(int p, int idx, int tag);
        fw_valid[p] = 1'b1; fw_index[p] = IW'(idx); fw_tag[p] = TW'(tag);
    endtask

    task automatic ud(int p, int idx, int op, int tag = 0, logic [31:0] val = '0);
        ud_valid[p] = 1'b1; ud_index[p] = IW'(idx); ud_op[p] = 2'(op); ud_tag[p] = TW'(tag); ud_value[p] = val;
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.name, e.port, observe(e.kind, e.port), e.exp);
        end
    endtask

    task automatic step();
        tick();
        fw_valid = '0;
        ud_valid = '0;
    endtask

    initial begin
        int n;
        #12;
        chk("rst_aging", 0, 32'(aging), 0);
        chk("rst_pred_valid", 0, 32'(pred_valid), 0);
        chk("rst_ack", 0, 32'(ud_ack), 0);
        rst_n = 1'b1;
        fw(0, 5, 'h3C); exp_pred(0, 1, 0, 0, 0, 0); step();
        ud(0, 5, 2, 'h3C, 32'hDEADBEEF); exp_ud(0, 1, 0); step();
        fw(0, 5, 'h3C); fw(1, 5, 'h3D);
        exp_pred(0, 1, 1, 32'hDEADBEEF, 0, 0); exp_pred(1, 1, 0, 32'hDEADBEEF, 0, 0); step();
        for (int i = 0; i < 8; i++) begin
            ud(0, 5, 0); exp_ud(0, 1, 0); step();
        end
        fw(0, 5, 'h3C); exp_pred(0, 1, 1, 32'hDEADBEEF, 7, 3); step();
        ud(0, 5, 1); exp_ud(0, 1, 0); step();
        fw(0, 5, 'h3C); exp_pred(0, 1, 1, 32'hDEADBEEF, 0, 2); step();
        ud(0, 9, 2, 'h11, 32'h99); step();
        ud(0, 9, 0); ud(1, 9, 2, 'h22, 32'h1234); exp_ud(0, 1, 0); exp_ud(1, 0, 0); step();
        fw(0, 9, 'h11); fw(1, 9, 'h22);
        exp_pred(0, 1, 1, 32'h99, 1, 1); exp_pred(1, 1, 0, 32'h99, 1, 1); step();
        ud(0, 7, 2, 'h77, 32'h7); ud(1, 30, 2, 'h30, 32'h30); exp_ud(0, 1, 0); exp_ud(1, 1, 0); step();
        ud(0, 7, 0); step();
        ud(0, 7, 0); step();
        for (int i = 0; i < 4; i++) begin
            ud(0, 7, 2, 'h78, 32'h8); exp_ud(0, 1, 1); step();
            chk("aging_before_sweep", i, 32'(aging), 0);
        end
        step();
        chk("aging_rise", 0, 32'(aging), 1);
        n = 1;
        for (int i = 0; i < 300; i++) begin
            if (i == 9) begin
                ud(0, 9, 0); exp_ud(0, 1, 0);
            end
            step();
            if (!aging) break;
            n++;
        end
        chk("sweep_len", 0, n, NE);
        fw(0, 7, 'h77); fw(1, 9, 'h11);
        exp_pred(0, 1, 1, 32'h7, 2, 1); exp_pred(1, 1, 1, 32'h99, 2, 2); step();
        fw(0, 5, 'h3C); fw(1, 30, 'h30);
        exp_pred(0, 1, 1, 32'hDEADBEEF, 0, 1); exp_pred(1, 1, 1, 32'h30, 0, 0); step();
        fw(0, 20, 'h55); ud(0, 20, 2, 'h55, 32'hABC);
        exp_pred(0, 1, 0, 0, 0, 0); exp_pred(1, 0, 0, 0, 0, 0); exp_ud(0, 1, 0); step();
        fw(0, 20, 'h55); exp_pred(0, 1, 1, 32'hABC, 0, 0); step();
        for (int i = 0; i < 2; i++) begin
            ud(0, 7, 2, 'h70, 32'h1); ud(1, 9, 2, 'h90, 32'h2); exp_ud(0, 1, 1); exp_ud(1, 1, 1); step();
        end
        step();
        chk("aging_rise2", 0, 32'(aging), 1);
        fw(0, 7, 'h77);
        for (int i = 0; i < 100; i++) tick();
        chk("mid_sweep_aging", 0, 32'(aging), 1);
        chk("mid_sweep_hit", 0, 32'(pred_hit[0]), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_aging", 0, 32'(aging), 0);
        chk("rst_mid_valid", 0, 32'(pred_valid), 0);
        chk("rst_mid_hit", 0, 32'(pred_hit), 0);
        chk("rst_mid_value", 0, pred_value[0], 0);
        chk("rst_mid_useful", 0, 32'(pred_useful[0]), 0);
        rst_n = 1'b1;
        fw(0, 7, 'h77); fw(1, 20, 'h55);
        exp_pred(0, 1, 0, 0, 0, 0); exp_pred(1, 1, 0, 0, 0, 0); step();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/vtage_bank_pipe.md
# vtage_bank_pipe

Parametrised, registered VTAGE tagged-component bank. Holds P_NUM_ENTRIES entries of {valid, tag, value, confidence, useful} and serves P_NUM_PRED lookup ports with one cycle of latency. It applies P_NUM_PRED update ports with deterministic collision resolution, and runs a background usefulness-aging sweep triggered by refused allocations. It is instantiated once per tagged component inside the VTAGE predictor; the base component lives elsewhere.

## Interface
- P_NUM_PRED, 2, number of lookup ports and number of update ports
- P_NUM_ENTRIES, 256, entries per bank; power of two, ≥ 2
- P_VALUE_WIDTH, 32, predicted value width
- P_TAG_WIDTH, 8, tag width
- P_CONF_WIDTH, 3, confidence counter width
- P_U_WIDTH, 2, useful counter width
- P_AGE_THRESH, 64, refused allocations that trigger an aging sweep; must be ≥ 1
- LP_INDEX_WIDTH (local), $clog2(P_NUM_ENTRIES)

Ports:
- clk_i  in  1  the only clock
- rst_ni  in  1  asynchronous reset, active-low
- fw_valid_i  in  [NP]  lookup request
- fw_index_i  in  [NP][LP_INDEX_WIDTH]  lookup index
- fw_tag_i  in  [NP][P_TAG_WIDTH]  lookup tag
- pred_valid_o  out  [NP]  registered fw_valid_i
- pred_hit_o  out  [NP]  entry valid and tag equal
- pred_value_o  out  [NP][P_VALUE_WIDTH]  entry value
- pred_conf_o  out  [NP][P_CONF_WIDTH]  entry confidence
- pred_useful_o  out  [NP][P_U_WIDTH]  entry useful counter
- ud_valid_i  in  [NP]  update request
- ud_index_i  in  [NP][LP_INDEX_WIDTH]  update index
- ud_op_i  in  [NP][2]  00 CORRECT, 01 WRONG, 10 ALLOC, 11 INVAL
- ud_tag_i  in  [NP][P_TAG_WIDTH]  tag for ALLOC
- ud_value_i  in  [NP][P_VALUE_WIDTH]  value for ALLOC
- ud_ack_o  out  [NP]  update applied; one cycle after request
- ud_refused_o  out  [NP]  ALLOC refused (entry useful); one cycle after request
- aging_o  out  1  aging sweep in progress

## Operation
- Reset (rst_ni low, asynchronous): every entry field is cleared to 0, including valid. All outputs go to 0. The age counter is 0 and the FSM is in IDLE.
- Lookup: pred_* outputs are registered from the entry contents as they stood at the clock edge, before that edge's updates (read-before-write).
  - When fw_valid_i=0, the port's value, conf, useful and hit outputs are 0.
  - On a miss, value, conf and useful still show the entry contents; pred_hit_o is 0.
- Update ops for an accepted port p:
  - CORRECT: conf saturating +1 (max 2^P_CONF_WIDTH−1); useful saturating +1.
  - WRONG: conf set to 0; useful saturating −1 (min 0).
  - ALLOC: applies only if entry valid=0 or useful=0. It then sets valid=1, tag=ud_tag_i, value=ud_value_i, conf=0, useful=0. Otherwise the entry is unchanged, ud_refused_o[p]=1 next cycle, and the age counter increments.
  - INVAL: valid=0. The other fields are kept.
- Collision: when several valid ports target the same index in a cycle, only the lowest-numbered port is applied. The others get ud_ack_o=0 and ud_refused_o=0, and are dropped.
  - ud_ack_o[p]=1 for the applied port, including a refused ALLOC.
- Age counter: increments by the number of refused ALLOCs in the cycle, saturating at P_AGE_THRESH.
- Aging FSM:
  - IDLE→SWEEP when the counter ≥ P_AGE_THRESH at a clock edge. On that transition the counter is cleared and the pointer set to 0.
  - SWEEP: each cycle, useful[ptr] is decremented by 1, saturating at 0. Then ptr increments.
  - After ptr = P_NUM_ENTRIES−1 is processed, the FSM returns to IDLE.
  - aging_o=1 exactly while in SWEEP.
  - Refused ALLOCs during SWEEP still count; a new sweep may start on the cycle after IDLE is re-entered.
- Sweep/update conflict: if an accepted update targets ptr in the same cycle, the update wins and that entry's decay is skipped. The pointer still advances.
- Lookups and updates are never stalled by aging.

## Timing
- Lookup latency: 1 cycle, fully pipelined, one request per port per cycle.
- Update latency: state changes at the edge that samples ud_valid_i. ud_ack_o and ud_refused_o are valid at the following cycle.
- An update at edge t is visible to lookups sampled at edge t+1 or later; a lookup at t sees the pre-update state.
- A sweep lasts exactly P_NUM_ENTRIES cycles.
- Reset assertion mid-sweep or mid-update returns everything to the reset state immediately. The first lookup after deassertion returns hit=0.

## Test plan
- Reset, then ALLOC idx 5, tag 0x3C, value 0xDEADBEEF on port 0; lookup idx 5, tag 0x3C the next cycle → pred_hit_o=1, value=0xDEADBEEF, conf=0, useful=0, one cycle after the lookup.
- Eight CORRECTs to idx 5 (P_CONF_WIDTH=3) → conf=7 (saturated), useful=3; one WRONG → conf=0, useful=2.
- Same cycle: port 0 CORRECT idx 9 and port 1 ALLOC idx 9 → ud_ack_o=01b (port 0 acked), port 1 dropped, entry 9 unchanged apart from the CORRECT.
- With useful=2 at idx 7 and P_AGE_THRESH=4: four refused ALLOCs → ud_refused_o=1 each time; aging_o rises next edge and stays high for 256 cycles; afterwards useful[7]=1.
- Lookup and ALLOC to the same idx at the same edge → lookup returns the old contents; a lookup on the next edge hits the new tag.
- Assert rst_ni mid-sweep at ptr=100 → aging_o=0 and all pred_* outputs 0 immediately; after release, all lookups miss.
